// File: rtl/async_fifo_rd_stream.sv
// Read-side streamer for asynchronous_fifo: prefetches FIFO words into a small skid
// buffer and presents them as a valid/ready stream in the rclk domain.
module async_fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  localparam int PW = $clog2(BUF_DEPTH);
  // wide enough for occupancy plus the in-flight word
  localparam int OW = $clog2(BUF_DEPTH + 2);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [OW-1:0]         r_occ;
  logic                  r_inflight;

  logic                  w_pop;
  logic                  w_cap;
  logic [OW-1:0]         w_need;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_pop     = m_valid && m_ready;
  assign w_cap     = r_inflight && !flush;
  assign w_need    = r_occ + OW'(r_inflight) - OW'(w_pop);
  assign fifo_r_en = rrst_n && !fifo_empty && !flush && (w_need < OW'(BUF_DEPTH));
  assign m_valid   = (r_occ != '0);
  assign m_data    = m_valid ? r_mem[r_rptr] : '0;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_occ      <= '0;
      r_inflight <= 1'b0;
      rd_count   <= '0;
    end else begin
      r_inflight <= fifo_r_en;
      if (w_pop) rd_count <= rd_count + CNT_WIDTH'(1);
      if (flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_occ  <= '0;
      end else begin
        if (w_cap) r_wptr <= ptr_inc(r_wptr);
        if (w_pop) r_rptr <= ptr_inc(r_rptr);
        r_occ <= r_occ + OW'(w_cap) - OW'(w_pop);
      end
    end
  end

  // storage needs no reset: m_data is gated by m_valid
  always_ff @(posedge rclk) begin
    if (w_cap) r_mem[r_wptr] <= fifo_rdata;
  end

endmodule
